gen_jtag_eng: RTL
=================

// Module: gen_jtag_eng
// PURPOSE
//  Parametrised JTAG master shift engine for DMB on-board chains. Successor to the
//  fixed 16-bit generator: wider registers, configurable TCK rate and a valid/ready
//  command interface. Supports TAP reset, IR/DR shifts with optional header/trailer,
//  and direct IR->DR transition. Sits between the VME command decoder and the chain pins.
// PARAMETERS
//  DW       32  shift data width in bits; max bits per command
//  NB_W     5   width of CMD_NBITS; must satisfy 2**NB_W >= DW
//  CLK_DIV  2   TCK half-period in FASTCLK cycles, >=1
// PORTS
//  FASTCLK    in   1     system clock; all logic on rising edge
//  RST_B      in   1     asynchronous active-low reset
//  CMD_VALID  in   1     command present
//  CMD_READY  out  1     engine idle, command accepted when VALID&READY
//  CMD_OP     in   2     0=DR shift, 1=IR shift, 2=IR->DR, 3=TAP reset
//  CMD_HDR    in   1     prepend header (RTI -> Shift-IR/DR)
//  CMD_TLR    in   1     append trailer (Exit1 -> RTI); ignored for OP 2,3
//  CMD_NBITS  in   NB_W  bits to shift minus 1
//  CMD_DATA   in   DW    TDI data, bit0 shifted first
//  TDO        in   1     chain TDO
//  TCK        out  1     chain clock
//  TMS        out  1     chain mode select
//  TDI        out  1     chain data in
//  RD_DATA    out  DW    captured TDO, right-justified
//  RD_VALID   out  1     one-cycle pulse when RD_DATA updated
//  BUSY       out  1     command in progress
// BEHAVIOUR
//  - Reset: TCK=0, TMS=1, TDI=0, RD_DATA=0, RD_VALID=0, BUSY=0, state IDLE.
//    CMD_READY=1 one cycle after RST_B deasserts. Reset mid-command aborts immediately.
//    The TAP state is then unknown; software issues OP 3.
//  - Handshake: CMD_READY = (state==IDLE). On accept, latch all CMD_* fields.
//    BUSY=1 and CMD_READY=0 from the next cycle. VALID while not READY is ignored.
//  - TCK: toggles every CLK_DIV cycles while BUSY; starts low, idles low.
//    TMS/TDI update on the FASTCLK that drives TCK low.
//    TDO is sampled on the FASTCLK that drives TCK high.
//  - Each TCK period = 1 tick. States and TMS sequences (LSB first):
//    IDLE  -> RST when OP=3, else IHEAD/DHEAD if CMD_HDR, else SHIFT
//    RST   -> TMS 1,1,1,1,1,0 (6 ticks), ends in RTI -> DONE
//    IHEAD -> TMS 1,1,0,0 (RTI->Shift-IR) -> SHIFT
//    DHEAD -> TMS 1,0,0 (RTI->Shift-DR) -> SHIFT
//    SHIFT -> NBITS+1 ticks; TDI = data[i]. TMS=0, except TMS=1 on the last bit
//             when a trailer or OP 2 follows.
//             Then TAIL (if CMD_TLR), T2H (if OP 2), else DONE (TAP stays in Shift).
//    TAIL  -> TMS 1,0 (Exit1->Update->RTI) -> DONE
//    T2H   -> TMS 1,1,0,0 (Exit1-IR->Update-IR->Sel-DR->Cap-DR->Shift-DR) -> DONE
//    DONE  -> one FASTCLK: RD_VALID pulse, BUSY=0 -> IDLE
//  - OP 3 ignores HDR/TLR/NBITS/DATA; TDI=0 throughout.
//  - NBITS >= DW is clamped to DW-1. NBITS=0 shifts exactly one bit.
//  - Bit counter counts down from NBITS. The last-bit flag is (cnt==0), no wrap.
//  - Total TCK periods = hdr + NBITS+1 + tlr. Latency accept->RD_VALID = that x 2*CLK_DIV + 2 cycles.
// CONFIGURATION
//  JTAG_TDO_CAPTURE_EN defined:
//   - TDO bit i is stored to RD_DATA[i]. Bits above NBITS are cleared at accept.
//   - RD_DATA holds until the next capturing command's DONE.
//   - RD_VALID pulses only for OP 0..2.
//  JTAG_TDO_CAPTURE_EN undefined:
//   - No capture logic. RD_DATA tied 0, RD_VALID tied 0.
//   - TDO unused; all other behaviour identical.
// TESTING
//  1 OP3 after reset -> exactly 6 TCK rising edges, TMS=1,1,1,1,1,0, BUSY high ~12*CLK_DIV cycles.
//  2 OP1 HDR=1 TLR=1 NBITS=4 DATA=0x15, TDO=TDI loopback -> TMS=1,1,0,0,0,0,0,0,1,1,0;
//    TDI=1,0,1,0,1; RD_DATA=0x15.
//  3 OP0 HDR=0 TLR=0 NBITS=31 DATA=0xA5A5_3C3C -> 32 ticks, TMS=0 throughout, RD_VALID once.
//  4 OP2 NBITS=7 DATA=0xFF -> TMS 1 on bit 7 then 1,1,0,0; no RTI visit.
//  5 RST_B low during SHIFT bit 10 -> TCK=0, TMS=1, BUSY=0 at once; READY=1 after release.
//  6 VALID held while BUSY, NBITS=40 with DW=32 -> second command accepted only after DONE;
//    32 bits shifted.

Source files
------------

// File: rtl/gen_jtag_eng_if.sv
// Command channel of the JTAG shift engine: valid/ready handshake plus latched command fields.
interface gen_jtag_eng_if #(
    parameter int DW   = 32,
    parameter int NB_W = 5
);
    logic            CMD_VALID;
    logic            CMD_READY;
    logic [1:0]      CMD_OP;
    logic            CMD_HDR;
    logic            CMD_TLR;
    logic [NB_W-1:0] CMD_NBITS;
    logic [DW-1:0]   CMD_DATA;

    modport master (
        output CMD_VALID, CMD_OP, CMD_HDR, CMD_TLR, CMD_NBITS, CMD_DATA,
        input  CMD_READY
    );

    modport slave (
        input  CMD_VALID, CMD_OP, CMD_HDR, CMD_TLR, CMD_NBITS, CMD_DATA,
        output CMD_READY
    );
endinterface

// File: rtl/gen_jtag_eng.sv
// JTAG master shift engine: TAP reset, IR/DR shifts with optional header/trailer, IR->DR hop.
// Optional TDO capture into RD_DATA is enabled by defining JTAG_TDO_CAPTURE_EN.
module gen_jtag_eng #(
    parameter int DW      = 32,
    parameter int NB_W    = 5,
    parameter int CLK_DIV = 2
) (
    input  logic          FASTCLK,
    input  logic          RST_B,
    gen_jtag_eng_if.slave cmd,
    input  logic          TDO,
    output logic          TCK,
    output logic          TMS,
    output logic          TDI,
    output logic [DW-1:0] RD_DATA,
    output logic          RD_VALID,
    output logic          BUSY
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RST   = 3'd1;
    localparam logic [2:0] S_IHEAD = 3'd2;
    localparam logic [2:0] S_DHEAD = 3'd3;
    localparam logic [2:0] S_SHIFT = 3'd4;
    localparam logic [2:0] S_TAIL  = 3'd5;
    localparam logic [2:0] S_T2H   = 3'd6;
    localparam logic [2:0] S_DONE  = 3'd7;

    localparam int                DIV_W    = $clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [NB_W:0]     DW_WIDE  = (NB_W + 1)'(DW);
    localparam logic [NB_W-1:0]   NB_MAX   = NB_W'(DW - 1);

    logic [2:0]       state, adv_state, first_ph;
    logic [2:0]       st, adv_st;
    logic [NB_W-1:0]  cnt, adv_cnt, nb_eff;
    logic [DW-1:0]    sr, adv_sr;
    logic [1:0]       op_q;
    logic             tlr_q, tail_q, first_tail;
    logic [DIV_W-1:0] div;
    logic             tck_q, tms_q, tdi_q, rdy_en;
    logic             accept, ticking;

    // TMS for a given tick; 'last' and 'tail' only matter while shifting.
    function automatic logic tms_of(input logic [2:0] ph, input logic [2:0] s,
                                    input logic last, input logic tail);
        case (ph)
            S_RST:          return s != 3'd5;
            S_IHEAD, S_T2H: return s < 3'd2;
            S_DHEAD, S_TAIL: return s == 3'd0;
            S_SHIFT:        return last && tail;
            default:        return 1'b0;
        endcase
    endfunction

    assign cmd.CMD_READY = (state == S_IDLE) && rdy_en;
    assign accept        = cmd.CMD_VALID && cmd.CMD_READY;
    assign ticking       = (state != S_IDLE) && (state != S_DONE);
    assign BUSY          = ticking;
    assign TCK           = tck_q;
    assign TMS           = tms_q;
    assign TDI           = tdi_q;

    always_comb begin
        nb_eff     = ({1'b0, cmd.CMD_NBITS} >= DW_WIDE) ? NB_MAX : cmd.CMD_NBITS;
        first_tail = (cmd.CMD_OP == 2'd2) || cmd.CMD_TLR;
        if (cmd.CMD_OP == 2'd3)
            first_ph = S_RST;
        else if (cmd.CMD_HDR)
            first_ph = (cmd.CMD_OP == 2'd0) ? S_DHEAD : S_IHEAD;
        else
            first_ph = S_SHIFT;
    end

    always_comb begin
        adv_state = state;
        adv_st    = st + 3'd1;
        adv_cnt   = cnt;
        adv_sr    = sr;
        case (state)
            S_RST:   if (st == 3'd5) begin adv_state = S_DONE;  adv_st = '0; end
            S_IHEAD: if (st == 3'd3) begin adv_state = S_SHIFT; adv_st = '0; end
            S_DHEAD: if (st == 3'd2) begin adv_state = S_SHIFT; adv_st = '0; end
            S_SHIFT: begin
                adv_st = '0;
                if (cnt == '0)
                    adv_state = (op_q == 2'd2) ? S_T2H : (tlr_q ? S_TAIL : S_DONE);
                else begin
                    adv_cnt = cnt - 1'b1;
                    adv_sr  = sr >> 1;
                end
            end
            S_TAIL:  if (st == 3'd1) begin adv_state = S_DONE; adv_st = '0; end
            S_T2H:   if (st == 3'd3) begin adv_state = S_DONE; adv_st = '0; end
            default: adv_st = '0;
        endcase
    end

    always_ff @(posedge FASTCLK or negedge RST_B) begin
        if (!RST_B) begin
            state  <= S_IDLE;
            st     <= '0;
            cnt    <= '0;
            sr     <= '0;
            op_q   <= '0;
            tlr_q  <= 1'b0;
            tail_q <= 1'b0;
            div    <= '0;
            tck_q  <= 1'b0;
            tms_q  <= 1'b1;
            tdi_q  <= 1'b0;
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            case (state)
                S_IDLE: if (accept) begin
                    state  <= first_ph;
                    st     <= '0;
                    cnt    <= nb_eff;
                    sr     <= cmd.CMD_DATA;
                    op_q   <= cmd.CMD_OP;
                    tlr_q  <= cmd.CMD_TLR && (cmd.CMD_OP != 2'd2);
                    tail_q <= first_tail;
                    div    <= '0;
                    tck_q  <= 1'b0;
                    tms_q  <= tms_of(first_ph, 3'd0, nb_eff == '0, first_tail);
                    tdi_q  <= (first_ph == S_SHIFT) ? cmd.CMD_DATA[0] : 1'b0;
                end
                S_DONE: state <= S_IDLE;
                default: begin
                    if (div != DIV_LAST)
                        div <= div + 1'b1;
                    else begin
                        div   <= '0;
                        tck_q <= ~tck_q;
                        // Falling TCK ends the tick: move on and present the next TMS/TDI.
                        if (tck_q) begin
                            state <= adv_state;
                            st    <= adv_st;
                            cnt   <= adv_cnt;
                            sr    <= adv_sr;
                            tdi_q <= (adv_state == S_SHIFT) ? adv_sr[0] : 1'b0;
                            if (adv_state != S_DONE)
                                tms_q <= tms_of(adv_state, adv_st, adv_cnt == '0, tail_q);
                        end
                    end
                end
            endcase
        end
    end

`ifdef JTAG_TDO_CAPTURE_EN
    logic [DW-1:0] cap_q, mask_q, rd_data_q;
    logic          rd_valid_q;

    always_ff @(posedge FASTCLK or negedge RST_B) begin
        if (!RST_B) begin
            cap_q      <= '0;
            mask_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            if (accept) begin
                cap_q  <= '0;
                mask_q <= DW'(1);
            end else if ((state == S_SHIFT) && (div == DIV_LAST)) begin
                if (!tck_q)
                    cap_q <= cap_q | (mask_q & {DW{TDO}});
                else
                    mask_q <= mask_q << 1;
            end
            if ((state == S_DONE) && (op_q != 2'd3)) begin
                rd_data_q  <= cap_q;
                rd_valid_q <= 1'b1;
            end
        end
    end

    assign RD_DATA  = rd_data_q;
    assign RD_VALID = rd_valid_q;
`else
    logic unused_tdo;
    assign unused_tdo = TDO;
    assign RD_DATA    = '0;
    assign RD_VALID   = 1'b0;
`endif
endmodule
